// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aes_pkg
// Description : Shared AES constants, FSM state type and S-box tables.
// Revision    : 1.0 - initial release
// ============================================================================
package aes_pkg;

  localparam int AES_STATE_W = 128;
  localparam int AES_BYTES   = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Forward S-box, element 0 is the leftmost byte of the first row.
  localparam logic [0:255][7:0] SBOX_FWD = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Inverse S-box, same element ordering as the forward table.
  localparam logic [0:255][7:0] SBOX_INV = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  // Single-byte substitution in either direction.
  function automatic logic [7:0] sbox_lookup(input logic [7:0] data, input logic inv);
    return inv ? SBOX_INV[data] : SBOX_FWD[data];
  endfunction

endpackage
`default_nettype wire

// File: rtl/aes_sbox_lut.sv
`default_nettype none
// ============================================================================
// Module      : aes_sbox_lut
// Description : Combinational one-byte AES S-box / inverse S-box lookup.
// Revision    : 1.0 - initial release
// ============================================================================
module aes_sbox_lut
  import aes_pkg::*;
(
  input  logic [7:0] data_i,
  input  logic       inv_i,
  output logic [7:0] data_o
);

  assign data_o = sbox_lookup(data_i, inv_i);

endmodule
`default_nettype wire

// File: rtl/sub_bytes_engine.sv
`default_nettype none
// ============================================================================
// Module      : sub_bytes_engine
// Description : Iterative AES SubBytes / InvSubBytes over a 128-bit state,
//               LANES bytes per clock, ready/valid on both sides.
// Revision    : 1.0 - initial release
// ============================================================================
module sub_bytes_engine
  import aes_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [AES_STATE_W-1:0] in_state,
  input  logic                   in_inv,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [AES_STATE_W-1:0] out_state,
  output logic                   busy
);

  // Counter step and the counter value of the last byte group. For LANES=16
  // the step truncates to 0, so the single group always sits at byte 0.
  localparam logic [3:0] LANE_STEP = 4'(LANES);
  localparam logic [3:0] LAST_CNT  = 4'(AES_BYTES - LANES);

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
    $error("sub_bytes_engine: LANES=%0d is not one of 1, 2, 4, 8, 16", LANES);
  end

  state_e                 state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [AES_STATE_W-1:0] work_q, work_d;
  logic                   inv_q, inv_d;
  logic                   accept;

  logic [7:0] lane_in  [LANES];
  logic [7:0] lane_out [LANES];

  assign accept    = in_valid && (state_q == IDLE);
  assign out_state = work_q;

  // Gather the bytes of the current group; cnt_q is always a multiple of
  // LANES, so cnt_q + g never wraps past byte 15.
  always_comb begin
    for (int g = 0; g < LANES; g++) begin
      lane_in[g] = work_q[{cnt_q + 4'(g), 3'b000} +: 8];
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    aes_sbox_lut u_lut (
      .data_i (lane_in[g]),
      .inv_i  (inv_q),
      .data_o (lane_out[g])
    );
  end

  // Datapath next state: load on accept, write back one byte group per SUB cycle.
  always_comb begin
    work_d = work_q;
    cnt_d  = cnt_q;
    inv_d  = inv_q;
    if (accept) begin
      work_d = in_state;
      cnt_d  = '0;
      inv_d  = in_inv;
    end else if (state_q == SUB) begin
      for (int g = 0; g < LANES; g++) begin
        work_d[{cnt_q + 4'(g), 3'b000} +: 8] = lane_out[g];
      end
      cnt_d = cnt_q + LANE_STEP;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      work_q <= '0;
      cnt_q  <= '0;
      inv_q  <= 1'b0;
    end else begin
      work_q <= work_d;
      cnt_q  <= cnt_d;
      inv_q  <= inv_d;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: the result is held in DONE until the downstream takes it.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept)            state_d = SUB;
      SUB:     if (cnt_q == LAST_CNT) state_d = DONE;
      DONE:    if (out_ready)         state_d = IDLE;
      default:                        state_d = IDLE;
    endcase
  end

  // FSM outputs, decoded from the registered state only.
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    busy      = (state_q != IDLE);
  end

endmodule
`default_nettype wire
